calc_screen_driver: RTL and testbench

- Converts one calculator number (`calc_pkg::num_t`) into per-digit seven-segment patterns, decimal point included, for the 8-digit display.
- Sits between the calculator datapath and the display multiplexer/pins.
- Does leading-zero blanking, decimal-point placement and minus-sign placement.
- Output is registered: one clock of latency.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/seven_seg_decoder.sv | 22 ++
 rtl/calc_screen_driver.sv | 74 +++++++
 tb/tb_calc_screen_driver.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared calculator number type and seven-segment constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

  localparam int NumDigits = 8;

  typedef struct packed {
    logic                          neg;
    logic [2:0]                    shift_amount;
    logic [NumDigits-1:0][3:0]     digits;
  } num_t;

  localparam logic [7:0] SegBlank = 8'h00;
  localparam logic [7:0] SegMinus = 8'h40;
  localparam logic [7:0] SegError = 8'h79;
  localparam int         DpBit    = 7;

  // Index n holds the {g,f,e,d,c,b,a} pattern for BCD digit n.
  localparam logic [9:0][6:0] SegDigits = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

`default_nettype wire

// File: rtl/seven_seg_decoder.sv
// ============================================================================
// Module   : seven_seg_decoder
// Purpose  : BCD to seven-segment pattern; non-BCD codes show 'E'.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seven_seg_decoder
  import calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegError[6:0];
    if (bcd <= 4'd9) seg = SegDigits[bcd];
  end

endmodule

`default_nettype wire

// File: rtl/calc_screen_driver.sv
// ============================================================================
// Module   : calc_screen_driver
// Purpose  : num_t to registered 8-digit segment image with blanking, dp, sign.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_screen_driver
  import calc_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  num_t                      num_i,
  input  logic                      override_shift_amount_i,
  input  logic [2:0]                new_shift_amount_i,
  output logic [NumDigits-1:0][7:0] display_segments_o
);

  logic [2:0]                w_shift;
  logic [NumDigits-1:0][6:0] w_dec;
  logic [NumDigits-1:0]      w_digit_nz;
  logic [NumDigits-1:0]      w_nz_above;
  logic [NumDigits-1:0]      w_keep;
  logic                      w_sign;
  logic                      w_overflow;
  logic [NumDigits-1:0][7:0] w_next;

  // A known-zero select keeps an X replacement shift out of the datapath.
  assign w_shift = override_shift_amount_i ? new_shift_amount_i : num_i.shift_amount;

  generate
    for (genvar gi = 0; gi < NumDigits; gi++) begin : g_dec
      seven_seg_decoder u_dec (
        .bcd (num_i.digits[gi]),
        .seg (w_dec[gi])
      );
      assign w_digit_nz[gi] = |num_i.digits[gi];
    end
  endgenerate

  always_comb begin
    w_nz_above = '0;
    w_keep     = '0;
    for (int i = 0; i < NumDigits; i++) begin
      w_nz_above[i] = |(w_digit_nz >> i);
      w_keep[i]     = (i <= int'(w_shift)) || w_nz_above[i];
    end
    w_sign     = num_i.neg && w_nz_above[0];
    w_overflow = w_sign && w_keep[NumDigits-1];
  end

  // Kept digits form a contiguous run from index 0, so the sign sits just above it.
  always_comb begin
    w_next = '0;
    for (int i = 0; i < NumDigits; i++) begin
      w_next[i] = w_keep[i] ? {1'b0, w_dec[i]} : SegBlank;
      if (w_shift != 3'd0 && i == int'(w_shift)) w_next[i][DpBit] = 1'b1;
    end
    for (int i = 1; i < NumDigits; i++) begin
      if (w_sign && !w_keep[i] && w_keep[i-1]) w_next[i] = SegMinus;
    end
    if (w_overflow) begin
      for (int i = 0; i < NumDigits; i++) w_next[i] = SegMinus;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) display_segments_o <= '0;
    else       display_segments_o <= w_next;
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_screen_driver.sv
// ============================================================================
// Module   : tb_calc_screen_driver
// Purpose  : Scoreboard bench for calc_screen_driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_calc_screen_driver;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  num_t        num;
  logic        ovr;
  logic [2:0]  nsa;
  logic [NumDigits-1:0][7:0] seg_out;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  calc_screen_driver dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .num_i                   (num),
    .override_shift_amount_i (ovr),
    .new_shift_amount_i      (nsa),
    .display_segments_o      (seg_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  function automatic num_t mk(input logic n, input logic [2:0] s, input logic [31:0] d);
    num_t r;
    r.neg = n;
    r.shift_amount = s;
    r.digits = d;
    return r;
  endfunction

  function automatic logic [7:0] dec(input logic [3:0] b);
    case (b)
      4'd0: return 8'h3F; 4'd1: return 8'h06; 4'd2: return 8'h5B; 4'd3: return 8'h4F;
      4'd4: return 8'h66; 4'd5: return 8'h6D; 4'd6: return 8'h7D; 4'd7: return 8'h07;
      4'd8: return 8'h7F; 4'd9: return 8'h6F; default: return 8'h79;
    endcase
  endfunction

  // Reference: highest shown digit is max(most significant nonzero, s).
  function automatic logic [63:0] model(input num_t n, input logic o, input logic [2:0] ns);
    logic [63:0] r;
    int s, msd, h;
    s = o ? int'(ns) : int'(n.shift_amount);
    msd = -1;
    for (int i = 0; i < 8; i++) if (n.digits[i] != 4'd0) msd = i;
    h = (msd > s) ? msd : s;
    r = '0;
    for (int i = 0; i <= h; i++) r[i*8 +: 8] = dec(n.digits[i]);
    if (s != 0) r[s*8+7] = 1'b1;
    if (n.neg && msd >= 0) begin
      if (h == 7) r = {8{8'h40}};
      else r[(h+1)*8 +: 8] = 8'h40;
    end
    return r;
  endfunction

  task automatic drive(input num_t n, input logic o, input logic [2:0] ns, input logic [63:0] e);
    num = n; ovr = o; nsa = ns;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [63:0] e);
    checks++;
    if (seg_out !== e) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, seg_out, e);
    end
  endtask

  // Monitor: one registered result per clock while the queue holds expectations.
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (seg_out !== e) begin
          errors++;
          $display("FAIL scoreboard @%0t: actual=%h required=%h", $time, seg_out, e);
        end
      end
    end
  end

  initial begin
    num_t rn;
    logic [31:0] rd;
    int len;
    rst = 1'b1;
    num = mk(1'b0, 3'd0, 32'h12345678);
    ovr = 1'b0;
    nsa = 3'd0;
    #3 check_now("reset_async", 64'h0);
    @(negedge clk);
    @(negedge clk);
    check_now("reset_held", 64'h0);
    rst = 1'b0;

    drive(mk(1'b0, 3'd0, 32'h12345678), 1'b0, 3'd0, 64'h065B4F666D7D077F);
    drive(mk(1'b0, 3'd3, 32'h00000042), 1'b0, 3'd0, 64'h00000000BF3F665B);
    drive(mk(1'b1, 3'd0, 32'h00000007), 1'b0, 3'd0, 64'h0000000000004007);
    drive(mk(1'b1, 3'd0, 32'h00000000), 1'b0, 3'd0, 64'h000000000000003F);
    drive(mk(1'b0, 3'd0, 32'h00001234), 1'b1, 3'd2, 64'h0000000006DB4F66);
    drive(mk(1'b0, 3'd0, 32'h00001234), 1'b0, 3'bxxx, 64'h00000000065B4F66);
    drive(mk(1'b1, 3'd0, 32'h98765432), 1'b0, 3'd0, 64'h4040404040404040);
    drive(mk(1'b0, 3'd0, 32'h0000000C), 1'b0, 3'd0, 64'h0000000000000079);
    drive(mk(1'b0, 3'd2, 32'h00000005), 1'b0, 3'd0, 64'h0000000000BF3F6D);
    drive(mk(1'b1, 3'd2, 32'h00000005), 1'b0, 3'd0, 64'h0000000040BF3F6D);
    drive(mk(1'b1, 3'd0, 32'h01234567), 1'b0, 3'd0, 64'h40065B4F666D7D07);
    drive(mk(1'b1, 3'd7, 32'h00000005), 1'b0, 3'd0, 64'h4040404040404040);
    drive(mk(1'b0, 3'd5, 32'h00000000), 1'b1, 3'd0, 64'h000000000000003F);

    // Mid-stream reset: the value presented now must never appear.
    num = mk(1'b0, 3'd0, 32'h00000099);
    #2 rst = 1'b1;
    #1 check_now("reset_mid_async", 64'h0);
    @(negedge clk);
    check_now("reset_mid_held", 64'h0);
    rst = 1'b0;

    for (int k = 0; k < 14; k++) begin
      len = $urandom_range(0, 8);
      rd = '0;
      for (int j = 0; j < len; j++) rd[j*4 +: 4] = 4'($urandom_range(0, 9));
      if (k == 5) rd[12 +: 4] = 4'hA;
      rn = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rd);
      ovr = 1'($urandom_range(0, 1));
      nsa = 3'($urandom_range(0, 7));
      drive(rn, ovr, nsa, model(rn, ovr, nsa));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
